alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU-control decode.
- Merges the aluop/funct decode with a registered execution datapath.
- Adds xor/nor/sltu, multi-cycle mult/multu/div/divu with internal HI/LO registers, and mfhi/mflo.
- Sits in EX, with a valid/ready handshake on both sides so a multi-cycle op can stall the pipeline.

---
 rtl/alu_exec_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with aluop/funct decode and a registered result.
// Single-cycle ops load the output register on the accept edge. mult/multu
// (shift-add) and div/divu (restoring) take WIDTH iterations plus one FIX
// cycle, then write HI/LO and load the output register with LO.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (aluop, funct, a, b sampled on accept)
//   out_valid / out_ready result handshake; result held until out_ready
//   result, zero, illegal registered response (illegal forces result 0)
module alu_exec_unit #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;       // raw operands, kept for sign fix-up
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sgn_q, sgn_d;   // signed variant
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     mag_q, mag_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   prod_q, prod_d; // mul: {acc, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 illegal_q, illegal_d;

    logic                 accept;
    logic [WIDTH-1:0]     dec_res;
    logic                 dec_ill, dec_mul, dec_div, dec_signed;
    logic [WIDTH-1:0]     a_abs, b_abs;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // ---------------- decode + single-cycle datapath ----------------
    always_comb begin
        dec_res = '0;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (aluop)
            2'b00: dec_res = a + b;
            2'b01: dec_res = a - b;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: dec_res = a + b;
                    6'b100010, 6'b100011: dec_res = a - b;
                    6'b100100: dec_res = a & b;
                    6'b100101: dec_res = a | b;
                    6'b100110: dec_res = a ^ b;
                    6'b100111: dec_res = ~(a | b);
                    6'b101010: dec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b101011: dec_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'b010000: if (MULDIV_EN) dec_res = hi_q; else dec_ill = 1'b1;
                    6'b010010: if (MULDIV_EN) dec_res = lo_q; else dec_ill = 1'b1;
                    6'b011000, 6'b011001: if (MULDIV_EN) dec_mul = 1'b1; else dec_ill = 1'b1;
                    6'b011010, 6'b011011: if (MULDIV_EN) dec_div = 1'b1; else dec_ill = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Even muldiv functs are the signed variants.
    assign dec_signed = !funct[0];
    assign a_abs      = (dec_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs      = (dec_signed && b[WIDTH-1]) ? -b : b;

    // ---------------- iteration steps ----------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the multiplier
        // LSB is set, then shift the whole {carry, acc, multiplier} right.
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        // Restoring: shift next dividend bit into the remainder, trial subtract.
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end

    // ---------------- sign fix-up ----------------
    logic                 sdiff;
    logic [2*WIDTH-1:0]   mul_fix;
    logic [WIDTH-1:0]     q_raw, r_raw, q_fix, r_fix, fix_hi, fix_lo;

    always_comb begin
        sdiff   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        mul_fix = sdiff ? -prod_q : prod_q;
        q_raw   = prod_q[WIDTH-1:0];
        r_raw   = prod_q[2*WIDTH-1:WIDTH];
        if (b_q == '0) begin
            // Divide by zero: fixed pattern, dividend passed through untouched.
            q_fix = '1;
            r_fix = a_q;
        end else begin
            q_fix = sdiff ? -q_raw : q_raw;
            r_fix = (sgn_q && a_q[WIDTH-1]) ? -r_raw : r_raw;
        end
        fix_hi = is_div_q ? r_fix : mul_fix[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? q_fix : mul_fix[WIDTH-1:0];
    end

    // ---------------- FSM / next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        is_div_d    = is_div_q;
        mag_d       = mag_q;
        prod_d      = prod_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_mul || dec_div) begin
                        a_d      = a;
                        b_d      = b;
                        sgn_d    = dec_signed;
                        is_div_d = dec_div;
                        cnt_d    = CW'(WIDTH-1);
                        mag_d    = dec_div ? b_abs : a_abs;
                        prod_d   = {{WIDTH{1'b0}}, dec_div ? a_abs : b_abs};
                        state_d  = dec_div ? S_DIV : S_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = dec_res;
                        zero_d      = (dec_res == '0);
                        illegal_d   = dec_ill;
                    end
                end
            end
            S_MUL, S_DIV: begin
                prod_d = (state_q == S_DIV) ? div_next : mul_next;
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                hi_d        = fix_hi;
                lo_d        = fix_lo;
                out_valid_d = 1'b1;
                result_d    = fix_lo;
                zero_d      = (fix_lo == '0);
                illegal_d   = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            is_div_q    <= 1'b0;
            mag_q       <= '0;
            prod_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            is_div_q    <= is_div_d;
            mag_q       <= mag_d;
            prod_q      <= prod_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against a behavioural model
// built on plain 64-bit arithmetic.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] a, b, result;

    logic         nm_in_valid, nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
    logic [W-1:0] nm_result;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    alu_exec_unit #(.WIDTH(W), .MULDIV_EN(1'b0)) u_dut_nm (
        .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b),
        .out_valid(nm_out_valid), .out_ready(1'b1),
        .result(nm_result), .zero(nm_zero), .illegal(nm_illegal)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS-style semantics from plain arithmetic; updates m_hi/m_lo.
    task automatic model(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic ill, output logic md);
        longint      sx, sy, q, rm;
        logic [63:0] p;
        r   = '0;
        ill = 1'b0;
        md  = 1'b0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        if (op == 2'd0)      r = x + y;
        else if (op == 2'd1) r = x - y;
        else if (op == 2'd3) ill = 1'b1;
        else begin
            case (fn)
                6'h20, 6'h21: r = x + y;
                6'h22, 6'h23: r = x - y;
                6'h24: r = x & y;
                6'h25: r = x | y;
                6'h26: r = x ^ y;
                6'h27: r = ~(x | y);
                6'h2a: r = (sx < sy) ? 1 : 0;
                6'h2b: r = (x < y) ? 1 : 0;
                6'h10: r = m_hi;
                6'h12: r = m_lo;
                6'h18, 6'h19: begin
                    if (fn == 6'h18) p = sx * sy;
                    else             p = {32'b0, x} * {32'b0, y};
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                    md   = 1'b1;
                end
                6'h1a, 6'h1b: begin
                    md = 1'b1;
                    if (y == 0) begin
                        m_lo = '1;
                        m_hi = x;
                    end else if (fn == 6'h1a) begin
                        q    = sx / sy;
                        rm   = sx % sy;
                        p    = q;
                        m_lo = p[31:0];
                        p    = rm;
                        m_hi = p[31:0];
                    end else begin
                        m_lo = x / y;
                        m_hi = x % y;
                    end
                end
                default: ill = 1'b1;
            endcase
            if (md) r = m_lo;
        end
    endtask

    // Issue one op with out_ready=1, check latency, busy window and response.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W-1:0] er;
        logic         ei, emd, busy_bad;
        int           n;
        @(negedge clk);
        in_valid = 1'b1; aluop = op; funct = fn; a = x; b = y;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk({tag, " accept"}, 64'(in_ready), 64'(1));
        model(op, fn, x, y, er, ei, emd);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluop = 2'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
        @(negedge clk);
        n = 0;
        busy_bad = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), emd ? 64'(W + 1) : 64'(0));
        if (emd) chk({tag, " busy"}, 64'(busy_bad), 64'(0));
        chk({tag, " result"},  64'(result),  64'(er));
        chk({tag, " illegal"}, 64'(illegal), 64'(ei));
        chk({tag, " zero"},    64'(zero),    64'(ei || (er == '0)));
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] fn_tab [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2a, 6'h2b, 6'h10, 6'h12, 6'h18, 6'h19,
                                6'h1a, 6'h1b, 6'h3f, 6'h01};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        logic [W-1:0] er;
        logic ei, emd;

        reset = 1'b1; in_valid = 1'b0; nm_in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; funct = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst result",    64'(result),    64'(0));
        chk("rst zero",      64'(zero),      64'(0));
        chk("rst illegal",   64'(illegal),   64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst in_ready",  64'(in_ready),  64'(1));

        // Directed scenarios, with literal expectations alongside the model.
        run_op(2'b10, 6'h20, 32'd5, 32'd7, "add");
        chk("add lit", 64'(result), 64'(12));
        run_op(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1, "slt");
        chk("slt lit", 64'(result), 64'(1));
        run_op(2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1, "sltu");
        chk("sltu lit", 64'(result), 64'(0));
        run_op(2'b01, 6'h00, 32'd9, 32'd9, "sub");
        chk("sub zero lit", 64'(zero), 64'(1));
        run_op(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3, "mult");
        chk("mult lit", 64'(result), 64'(32'hFFFF_FFFA));
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi mult");
        chk("mfhi mult lit", 64'(result), 64'(32'hFFFF_FFFF));
        run_op(2'b10, 6'h1a, -32'sd7, 32'd2, "div");
        chk("div lit", 64'(result), 64'(32'hFFFF_FFFD));
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi div");
        chk("mfhi div lit", 64'(result), 64'(32'hFFFF_FFFF));
        run_op(2'b10, 6'h1b, 32'd7, 32'd0, "divu0");
        chk("divu0 lit", 64'(result), 64'(32'hFFFF_FFFF));
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi divu0");
        chk("mfhi divu0 lit", 64'(result), 64'(7));
        run_op(2'b10, 6'h1a, 32'hFFFF_FFF9, 32'd0, "div0 neg");
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi div0 neg");
        run_op(2'b10, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg");
        chk("div minneg lit", 64'(result), 64'(32'h8000_0000));
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi minneg");
        run_op(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi multu");
        run_op(2'b11, 6'h20, 32'd3, 32'd4, "aluop11");
        chk("aluop11 lit", 64'(result), 64'(0));

        // Backpressure: result held while out_ready low, next op waits.
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b00; a = 32'd20; b = 32'd22;
        chk("bp first accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0; aluop = 2'b01; a = 32'd50; b = 32'd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp out_valid", 64'(out_valid), 64'(1));
            chk("bp in_ready",  64'(in_ready),  64'(0));
            chk("bp result",    64'(result),    64'(42));
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp drain out_valid", 64'(out_valid), 64'(1));
        chk("bp drain result",    64'(result),    64'(42));

        // Reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'h1a; a = 32'd100; b = 32'd7;
        chk("mid div accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("mid rst out_valid", 64'(out_valid), 64'(0));
        chk("mid rst in_ready",  64'(in_ready),  64'(1));
        run_op(2'b10, 6'h10, 32'd0, 32'd0, "mfhi after rst");
        run_op(2'b10, 6'h12, 32'd0, 32'd0, "mflo after rst");

        // MULDIV_EN=0 instance: mult is illegal and completes in one cycle.
        @(negedge clk);
        nm_in_valid = 1'b1; aluop = 2'b10; funct = 6'h18; a = 32'd3; b = 32'd4;
        chk("nm in_ready", 64'(nm_in_ready), 64'(1));
        @(posedge clk);
        #1;
        nm_in_valid = 1'b0;
        @(negedge clk);
        chk("nm out_valid", 64'(nm_out_valid), 64'(1));
        chk("nm illegal",   64'(nm_illegal),   64'(1));
        chk("nm result",    64'(nm_result),    64'(0));
        chk("nm zero",      64'(nm_zero),      64'(1));

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 21);
            if (k < 2)       op = 2'(k);
            else if (k == 2) op = 2'b11;
            else             op = 2'b10;
            fn = (k == 21) ? 6'($urandom) : fn_tab[$urandom_range(0, 17)];
            run_op(op, fn, rnd_opnd(), rnd_opnd(), $sformatf("rnd%0d op%0d fn%0h", i, op, fn));
        end

        // Keep the model's view of the last op for a final consistency probe.
        model(2'b10, 6'h12, '0, '0, er, ei, emd);
        run_op(2'b10, 6'h12, 32'd0, 32'd0, "final mflo");
        chk("final mflo model", 64'(result), 64'(er));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
